// File: rtl/music_seq_pkg.sv
// Shared types and constants for the note sequencer: note entry layout,
// FSM state encoding and a few phase increments for a 12.5 MHz clock.
package music_seq_pkg;

  localparam int NOTE_W = 24;

  localparam logic [15:0] G4  = 16'd4208;
  localparam logic [15:0] DS4 = 16'd3339;
  localparam logic [15:0] AS4 = 16'd5005;

  typedef struct packed {
    logic        last;
    logic        rest;
    logic [5:0]  dur;
    logic [15:0] freq;
  } note_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_GAP
  } seq_state_t;

  // A zero duration still plays for one tick.
  function automatic logic [5:0] eff_dur(input logic [5:0] dur);
    return (dur == 6'd0) ? 6'd1 : dur;
  endfunction

endpackage

// File: rtl/music_seq_tick_div.sv
// Duration tick divider: free-running modulo-TICK_DIV counter with a
// synchronous clear; tick_o pulses on the last count of each period.
module music_seq_tick_div #(
  parameter int TICK_DIV = 3125000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tick_o = ~clr_i && (cnt_q == LAST);

endmodule

// File: rtl/music_sequencer.sv
// Song memory plus playback FSM driving audio_channel en/freq.
// Define MUSIC_SEQ_ARTIC_EN to spend the final tick of longer notes silent.
module music_sequencer
  import music_seq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 3125000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_addr_i,
  input  logic [NOTE_W-1:0]        wr_data_i,
  input  logic                     start_i,
  input  logic                     stop_i,
  input  logic                     loop_i,
  output logic                     en_o,
  output logic [15:0]              freq_o,
  output logic [$clog2(DEPTH)-1:0] note_idx_o,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int AW = $clog2(DEPTH);

  seq_state_t    state_q, state_d;
  note_t         mem [DEPTH];
  note_t         rd_q;
  logic [AW-1:0] idx_q;
  logic [5:0]    rem_q;
  logic          load_q;
  logic          tick;
  logic          in_note;
  logic          note_end;
  logic          song_end;
  logic          gap_enter;
  logic          play_en;

  assign in_note = (state_q == S_PLAY) || (state_q == S_GAP);

  music_seq_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (~in_note),
    .tick_o (tick)
  );

  // NOTE: the song array has no reset so it maps onto block RAM; only the
  // control path around it is reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= note_t'(wr_data_i);
    end
    if (state_q == S_FETCH) begin
      rd_q <= mem[idx_q];
    end
  end

  // rem_q is loaded one cycle after FETCH, once the RAM word is available.
  assign note_end = in_note && tick && !load_q && (rem_q == 6'd1);
  assign song_end = note_end && rd_q.last && !loop_i;

`ifdef MUSIC_SEQ_ARTIC_EN
  assign gap_enter = (state_q == S_PLAY) && tick && !load_q &&
                     (rem_q == 6'd2) && !rd_q.rest;
`else
  assign gap_enter = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (stop_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_i) state_d = S_FETCH;
        S_FETCH: state_d = S_PLAY;
        S_PLAY, S_GAP: begin
          if (note_end) begin
            state_d = song_end ? S_IDLE : S_FETCH;
          end else if (gap_enter) begin
            state_d = S_GAP;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy_o  = (state_q != S_IDLE);
    play_en = (state_q == S_PLAY) && !rd_q.rest;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      load_q <= 1'b0;
      rem_q  <= '0;
      idx_q  <= '0;
    end else begin
      load_q <= (state_q == S_FETCH);
      if (load_q) begin
        rem_q <= eff_dur(rd_q.dur);
      end else if (tick && rem_q != 6'd0) begin
        rem_q <= rem_q - 6'd1;
      end
      if (!stop_i) begin
        if (state_q == S_IDLE && start_i) begin
          idx_q <= '0;
        end else if (note_end && !song_end) begin
          idx_q <= rd_q.last ? '0 : idx_q + AW'(1);
        end
      end
    end
  end

  // Outputs trail the FSM by one cycle because the entry is read from RAM
  // at the FETCH edge; stop silences the channel on its own edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      en_o   <= 1'b0;
      freq_o <= '0;
      done_o <= 1'b0;
    end else begin
      en_o   <= play_en && !stop_i;
      done_o <= song_end && !stop_i;
      if (state_q == S_PLAY) begin
        freq_o <= rd_q.freq;
      end
    end
  end

  assign note_idx_o = idx_q;

endmodule
